// File: rtl/spi_target_frontend.sv
// SPI target byte engine: oversampled SCLK/CS/MOSI, 8-bit MSB-first frames, SCLK idle low, sample on falling edge.
// Optional MISO output-enable port and hold-in-idle behaviour under `SPI_TARGET_MISO_OE_EN.
module spi_target_frontend #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       underrun_o,
  output logic       abort_o,
  input  logic       spi_cs_i,
  input  logic       spi_clk_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o
`ifdef SPI_TARGET_MISO_OE_EN
  ,
  output logic       spi_miso_oe_o
`endif
);

  typedef enum logic [1:0] {IDLE, SELECTED, SHIFT} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_p, cs_p;
  logic sclk_s, cs_s, mosi_s;
  logic rise, fall, cs_on, cs_off;

  logic [7:0] tx_shift, rx_shift, hold_data;
  logic       hold_full;
  logic [3:0] bit_cnt;

  logic do_load, do_shift_tx, do_sample, byte_done, do_abort;
  logic clear_rx, set_cnt, clr_cnt;

  // NOTE: every flop uses non-blocking assignment so all registers see pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_p    <= 1'b0;
      cs_p      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_p    <= sclk_sync[SYNC_STAGES-1];
      cs_p      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_p;
  assign fall   = ~sclk_s & sclk_p;
  assign cs_on  = cs_s & ~cs_p;
  assign cs_off = ~cs_s & cs_p;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next  = state;
    do_load     = 1'b0;
    do_shift_tx = 1'b0;
    do_sample   = 1'b0;
    byte_done   = 1'b0;
    do_abort    = 1'b0;
    clear_rx    = 1'b0;
    set_cnt     = 1'b0;
    clr_cnt     = 1'b0;
    if (cs_off || !cs_s) begin
      // Deselect beats any SCLK edge seen in the same cycle.
      state_next = IDLE;
      clr_cnt    = 1'b1;
      do_abort   = (state != IDLE) && (bit_cnt != 4'd0) && (bit_cnt < 4'd8);
    end else begin
      case (state)
        IDLE: begin
          if (cs_on) begin
            do_load    = 1'b1;
            set_cnt    = 1'b1;
            clear_rx   = 1'b1;
            state_next = SELECTED;
          end
        end
        SELECTED: begin
          if (rise) state_next = SHIFT;
        end
        SHIFT: begin
          if (rise && bit_cnt < 4'd8) do_shift_tx = 1'b1;
          if (fall) begin
            do_sample = 1'b1;
            if (bit_cnt == 4'd1) begin
              byte_done  = 1'b1;
              do_load    = 1'b1;
              set_cnt    = 1'b1;
              state_next = SELECTED;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_shift   <= 8'h00;
      rx_shift   <= 8'h00;
      hold_data  <= 8'h00;
      hold_full  <= 1'b0;
      bit_cnt    <= 4'd0;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      underrun_o <= 1'b0;
      abort_o    <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      underrun_o <= 1'b0;
      abort_o    <= do_abort;

      if (do_load) begin
        tx_shift   <= hold_full ? hold_data : 8'h00;
        hold_full  <= 1'b0;
        underrun_o <= ~hold_full;
      end else if (do_shift_tx) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      // An accept coinciding with a load lands after the load, so it waits for the next boundary.
      if (tx_valid_i && !hold_full) begin
        hold_data <= tx_data_i;
        hold_full <= 1'b1;
      end

      if (clear_rx)       rx_shift <= 8'h00;
      else if (do_sample) rx_shift <= {rx_shift[6:0], mosi_s};

      if (clr_cnt)        bit_cnt <= 4'd0;
      else if (set_cnt)   bit_cnt <= 4'd8;
      else if (do_sample) bit_cnt <= bit_cnt - 4'd1;

      if (byte_done) begin
        rx_data_o  <= {rx_shift[6:0], mosi_s};
        rx_valid_o <= 1'b1;
      end
    end
  end

  assign tx_ready_o = ~hold_full;

`ifdef SPI_TARGET_MISO_OE_EN
  // tx_shift is frozen in IDLE, so MISO keeps its last bit while the pad is released.
  assign spi_miso_oe_o = (state != IDLE);
  assign spi_miso_o    = tx_shift[7];
`else
  assign spi_miso_o    = (state != IDLE) ? tx_shift[7] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_target_frontend.sv
// Directed bench for spi_target_frontend: table of single-byte frames plus hand sequences
// for back-to-back bytes, abort, mid-frame reset and (when built with it) MISO output enable.
module tb_spi_target_frontend;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       underrun_o;
  logic       abort_o;
  logic       spi_cs_i;
  logic       spi_clk_i;
  logic       spi_mosi_i;
  logic       spi_miso_o;
`ifdef SPI_TARGET_MISO_OE_EN
  logic       spi_miso_oe_o;
`endif

  spi_target_frontend dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .underrun_o (underrun_o),
    .abort_o    (abort_o),
    .spi_cs_i   (spi_cs_i),
    .spi_clk_i  (spi_clk_i),
    .spi_mosi_i (spi_mosi_i),
    .spi_miso_o (spi_miso_o)
`ifdef SPI_TARGET_MISO_OE_EN
    ,
    .spi_miso_oe_o (spi_miso_oe_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int und_cnt = 0;
  int abt_cnt = 0;
  logic [7:0] rx_log[$];

  always @(negedge clk_i) begin
    if (rx_valid_o) begin
      rx_cnt++;
      rx_log.push_back(rx_data_o);
    end
    if (underrun_o) und_cnt++;
    if (abort_o) abt_cnt++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic push(input logic [7:0] d);
    int t = 0;
    while (!tx_ready_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (!tx_ready_o) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: tx_ready_o stuck at 0, expected 1 within 100 cycles");
    end
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
  endtask

  // One SCLK period (clk/8): launch MOSI with the rise, read MISO just before the fall.
  task automatic xfer_bit(input logic b, output logic m);
    spi_mosi_i = b;
    spi_clk_i  = 1'b1;
    wait_clks(4);
    m = spi_miso_o;
    spi_clk_i = 1'b0;
    wait_clks(4);
  endtask

  task automatic xfer_byte(input logic [7:0] mosi, output logic [7:0] miso);
    for (int i = 7; i >= 0; i--) begin
      logic m;
      xfer_bit(mosi[i], m);
      miso[i] = m;
    end
  endtask

  task automatic cs_up();
    spi_cs_i = 1'b1;
    wait_clks(8);
  endtask

  task automatic cs_down();
    wait_clks(4);
    spi_cs_i = 1'b0;
    wait_clks(8);
  endtask

  // A filler byte is supplied after selection so the end-of-byte load is never empty.
  task automatic run_frame(input bit preload, input logic [7:0] tx, input logic [7:0] mosi,
                           output logic [7:0] miso);
    if (preload) push(tx);
    cs_up();
    push(8'hE7);
    xfer_byte(mosi, miso);
    cs_down();
  endtask

  typedef struct {
    bit         preload;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_und;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] miso, miso2;
    int r0, u0, a0, base;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
    vecs[1] = '{1'b0, 8'h00, 8'h55, 8'h00, 8'h55, 1};
    vecs[2] = '{1'b1, 8'hC3, 8'h81, 8'hC3, 8'h81, 0};
    vecs[3] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 0};
    vecs[4] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};

    rst_i      = 1'b1;
    tx_data_i  = 8'h00;
    tx_valid_i = 1'b0;
    spi_cs_i   = 1'b0;
    spi_clk_i  = 1'b0;
    spi_mosi_i = 1'b0;
    wait_clks(3);
    check("rst_tx_ready", tx_ready_o, 1);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_underrun", underrun_o, 0);
    check("rst_abort", abort_o, 0);
    check("rst_miso", spi_miso_o, 0);
    check("rst_rx_data", rx_data_o, 8'h00);
    rst_i = 1'b0;
    wait_clks(4);

`ifdef SPI_TARGET_MISO_OE_EN
    check("oe_idle", spi_miso_oe_o, 0);
    spi_cs_i = 1'b1;
    wait_clks(4);
    check("oe_selected", spi_miso_oe_o, 1);
    spi_cs_i = 1'b0;
    wait_clks(4);
    check("oe_deselected", spi_miso_oe_o, 0);
    wait_clks(4);
    // That bare select consumed nothing but counted as an empty load.
    und_cnt = 0;
`endif

    for (int i = 0; i < 5; i++) begin
      r0 = rx_cnt; u0 = und_cnt; a0 = abt_cnt;
      run_frame(vecs[i].preload, vecs[i].tx, vecs[i].mosi, miso);
      check($sformatf("v%0d_miso", i), miso, vecs[i].exp_miso);
      check($sformatf("v%0d_rx_data", i), rx_data_o, vecs[i].exp_rx);
      check($sformatf("v%0d_rx_pulses", i), rx_cnt - r0, 1);
      check($sformatf("v%0d_underruns", i), und_cnt - u0, vecs[i].exp_und);
      check($sformatf("v%0d_aborts", i), abt_cnt - a0, 0);
      check($sformatf("v%0d_tx_ready", i), tx_ready_o, 1);
    end

    // Back-to-back bytes under one CS, second tx byte supplied mid-frame.
    r0 = rx_cnt; u0 = und_cnt; a0 = abt_cnt; base = rx_log.size();
    push(8'h12);
    cs_up();
    push(8'h34);
    xfer_byte(8'hF0, miso);
    push(8'hE7);
    xfer_byte(8'h0F, miso2);
    cs_down();
    check("b2b_miso0", miso, 8'h12);
    check("b2b_miso1", miso2, 8'h34);
    check("b2b_rx_pulses", rx_cnt - r0, 2);
    if (rx_log.size() >= base + 2) begin
      check("b2b_rx0", rx_log[base], 8'hF0);
      check("b2b_rx1", rx_log[base+1], 8'h0F);
    end else begin
      checks++;
      errors++;
      $display("FAIL b2b_rx_log: got %0d bytes, expected 2", rx_log.size() - base);
    end
    check("b2b_underruns", und_cnt - u0, 0);

    // Deselect after 5 falls: partial byte discarded, abort pulses once.
    r0 = rx_cnt; u0 = und_cnt; a0 = abt_cnt;
    push(8'h96);
    cs_up();
    for (int i = 0; i < 5; i++) begin
      logic m;
      xfer_bit(1'b1, m);
    end
    cs_down();
    check("abort_pulses", abt_cnt - a0, 1);
    check("abort_rx_pulses", rx_cnt - r0, 0);
    check("abort_underruns", und_cnt - u0, 0);
    check("abort_miso_idle", spi_miso_o, 0);
    r0 = rx_cnt;
    run_frame(1'b1, 8'h5A, 8'hA6, miso);
    check("post_abort_miso", miso, 8'h5A);
    check("post_abort_rx", rx_data_o, 8'hA6);
    check("post_abort_rx_pulses", rx_cnt - r0, 1);

    // Async reset between clock edges in the middle of a frame.
    push(8'hFF);
    cs_up();
    push(8'h00);
    for (int i = 0; i < 3; i++) begin
      logic m;
      xfer_bit(1'b0, m);
    end
    check("pre_rst_miso", spi_miso_o, 1);
    check("pre_rst_tx_ready", tx_ready_o, 0);
    r0 = rx_cnt; u0 = und_cnt; a0 = abt_cnt;
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_miso", spi_miso_o, 0);
    check("mid_rst_tx_ready", tx_ready_o, 1);
    check("mid_rst_rx_data", rx_data_o, 8'h00);
    check("mid_rst_rx_valid", rx_valid_o, 0);
    spi_cs_i = 1'b0;
    wait_clks(3);
    rst_i = 1'b0;
    wait_clks(8);
    check("rst_no_abort", abt_cnt - a0, 0);
    check("rst_no_rx", rx_cnt - r0, 0);
    check("rst_no_underrun", und_cnt - u0, 0);
    r0 = rx_cnt;
    run_frame(1'b1, 8'h69, 8'hC3, miso);
    check("post_rst_miso", miso, 8'h69);
    check("post_rst_rx", rx_data_o, 8'hC3);
    check("post_rst_rx_pulses", rx_cnt - r0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
